// File: rtl/config_loader.sv
// config_loader
//    Streams a 56-word configuration frame into 24 LUT memories and 8 switch-block
//    configure registers. One frame is 8 slices of 7 words, and slices load from 7
//    down to 0. Within a slice:
//       offsets 0,2,4 : LUT low word, held until its partner word arrives
//       offsets 1,3,5 : LUT high bit, which triggers the 33-bit LUT write
//       offset  6     : switch-block value, which triggers the SB write
//    Every write strobe is registered, so it appears the cycle after the word is accepted.
//
//    state | meaning
//    ------+-------------------------------------------------------------
//    IDLE  | after reset; waits for start
//    LOAD  | in_ready high; accepts words until the 56th is taken
//    DONE  | frame complete; fabric_en high; start begins a new frame
//
// Ports
//    clock, reset_n          rising-edge clock, asynchronous active-low reset
//    start                   begin a frame (ignored while loading)
//    in_data/in_valid        word stream; in_ready is high only while loading
//    lut_wr_en/sel/data      LUT write strobe, index 0..23, 33-bit contents
//    sb_wr_en/sel/data       switch-block write strobe, index 0..7, 16-bit value
//    fabric_en               configuration complete
//    word_cnt                words accepted in the current frame, 0..56
//    fmt_err                 sticky format-violation flag for the current frame

module config_loader (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        lut_wr_en,
   output logic [4:0]  lut_sel,
   output logic [32:0] lut_data,
   output logic        sb_wr_en,
   output logic [2:0]  sb_sel,
   output logic [15:0] sb_data,
   output logic        fabric_en,
   output logic [5:0]  word_cnt,
   output logic        fmt_err
);

   localparam logic [5:0] WORDS_PER_FRAME = 6'd56;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic [5:0]  word_cnt_q, word_cnt_d;
   logic [2:0]  offset_q, offset_d;
   logic [2:0]  slice_q, slice_d;
   logic [31:0] low_word_q, low_word_d;
   logic        fmt_err_q, fmt_err_d;
   logic        lut_wr_en_q, lut_wr_en_d;
   logic [4:0]  lut_sel_q, lut_sel_d;
   logic [32:0] lut_data_q, lut_data_d;
   logic        sb_wr_en_q, sb_wr_en_d;
   logic [2:0]  sb_sel_q, sb_sel_d;
   logic [15:0] sb_data_q, sb_data_d;

   logic        accept;
   logic        load_entry;
   logic        last_word;

   assign accept     = in_valid && (state_q == ST_LOAD);
   assign load_entry = start && (state_q != ST_LOAD);
   assign last_word  = accept && (word_cnt_q == WORDS_PER_FRAME - 6'd1);

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)     state_d = ST_LOAD;
         ST_LOAD: if (last_word) state_d = ST_DONE;
         ST_DONE: if (start)     state_d = ST_LOAD;
         default:                state_d = ST_IDLE;
      endcase
   end

   // state outputs
   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      fabric_en = (state_q == ST_DONE);
   end

   // datapath
   always_comb begin
      word_cnt_d  = word_cnt_q;
      offset_d    = offset_q;
      slice_d     = slice_q;
      low_word_d  = low_word_q;
      fmt_err_d   = fmt_err_q;
      lut_wr_en_d = 1'b0;
      lut_sel_d   = lut_sel_q;
      lut_data_d  = lut_data_q;
      sb_wr_en_d  = 1'b0;
      sb_sel_d    = sb_sel_q;
      sb_data_d   = sb_data_q;

      if (load_entry) begin
         word_cnt_d = 6'd0;
         offset_d   = 3'd0;
         slice_d    = 3'd7;
         fmt_err_d  = 1'b0;
      end else if (accept) begin
         if (word_cnt_q != WORDS_PER_FRAME) begin
            word_cnt_d = word_cnt_q + 6'd1;
         end
         case (offset_q)
            3'd0, 3'd2, 3'd4: begin
               low_word_d = in_data;
               offset_d   = offset_q + 3'd1;
            end
            3'd1, 3'd3, 3'd5: begin
               // offset>>1 is the LUT number within the slice (0,1,2)
               lut_wr_en_d = 1'b1;
               lut_sel_d   = 5'(slice_q) * 5'd3 + 5'(offset_q[2:1]);
               lut_data_d  = {in_data[0], low_word_q};
               if (in_data[31:1] != 31'd0) fmt_err_d = 1'b1;
               offset_d    = offset_q + 3'd1;
            end
            default: begin
               sb_wr_en_d = 1'b1;
               sb_sel_d   = slice_q;
               sb_data_d  = in_data[15:0];
               if (in_data[31:16] != 16'd0) fmt_err_d = 1'b1;
               offset_d   = 3'd0;
               slice_d    = slice_q - 3'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word_cnt_q  <= 6'd0;
         offset_q    <= 3'd0;
         slice_q     <= 3'd7;
         low_word_q  <= 32'd0;
         fmt_err_q   <= 1'b0;
         lut_wr_en_q <= 1'b0;
         lut_sel_q   <= 5'd0;
         lut_data_q  <= 33'd0;
         sb_wr_en_q  <= 1'b0;
         sb_sel_q    <= 3'd0;
         sb_data_q   <= 16'd0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         offset_q    <= offset_d;
         slice_q     <= slice_d;
         low_word_q  <= low_word_d;
         fmt_err_q   <= fmt_err_d;
         lut_wr_en_q <= lut_wr_en_d;
         lut_sel_q   <= lut_sel_d;
         lut_data_q  <= lut_data_d;
         sb_wr_en_q  <= sb_wr_en_d;
         sb_sel_q    <= sb_sel_d;
         sb_data_q   <= sb_data_d;
      end
   end

   assign lut_wr_en = lut_wr_en_q;
   assign lut_sel   = lut_sel_q;
   assign lut_data  = lut_data_q;
   assign sb_wr_en  = sb_wr_en_q;
   assign sb_sel    = sb_sel_q;
   assign sb_data   = sb_data_q;
   assign word_cnt  = word_cnt_q;
   assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: the driver pushes each expected write into a scoreboard
// queue when the word is accepted; a negedge monitor pops and compares strobes.
module tb_config_loader;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        lut_wr_en;
   logic [4:0]  lut_sel;
   logic [32:0] lut_data;
   logic        sb_wr_en;
   logic [2:0]  sb_sel;
   logic [15:0] sb_data;
   logic        fabric_en;
   logic [5:0]  word_cnt;
   logic        fmt_err;

   config_loader dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .lut_wr_en (lut_wr_en),
      .lut_sel   (lut_sel),
      .lut_data  (lut_data),
      .sb_wr_en  (sb_wr_en),
      .sb_sel    (sb_sel),
      .sb_data   (sb_data),
      .fabric_en (fabric_en),
      .word_cnt  (word_cnt),
      .fmt_err   (fmt_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          is_lut;
      int          sel;
      logic [32:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] words[56];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          model_err;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clock) begin
      if (reset_n) begin
         if (lut_wr_en && sb_wr_en) check("strobe_overlap", 64'(2'b11), 64'(2'b00));
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind", 64'({lut_wr_en, sb_wr_en}), e.is_lut ? 64'(2'b10) : 64'(2'b01));
            if (e.is_lut) begin
               check("lut_sel", 64'(lut_sel), 64'(e.sel));
               check("lut_data", 64'(lut_data), 64'(e.data));
            end else begin
               check("sb_sel", 64'(sb_sel), 64'(e.sel));
               check("sb_data", 64'(sb_data), 64'(e.data[15:0]));
            end
         end else if (lut_wr_en || sb_wr_en) begin
            check("unexpected_strobe", 64'({lut_wr_en, sb_wr_en}), 64'(2'b00));
         end
      end
   end

   // reference model: what accepting word w of the frame must produce
   task automatic model_accept(input int w);
      int   o, s;
      exp_t e;
      o = w % 7;
      s = 7 - w / 7;
      e.cyc = cyc + 1;
      if (o == 1 || o == 3 || o == 5) begin
         e.is_lut = 1'b1;
         e.sel    = s * 3 + (o - 1) / 2;
         e.data   = {words[w][0], words[w - 1]};
         if (words[w] > 32'd1) model_err = 1'b1;
         exp_q.push_back(e);
      end else if (o == 6) begin
         e.is_lut = 1'b0;
         e.sel    = s;
         e.data   = {17'd0, words[w][15:0]};
         if (words[w] > 32'h0000_FFFF) model_err = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // called at a negedge; returns at the negedge after the start edge
   task automatic send_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      model_err = 1'b0;
   endtask

   // mode 0: back-to-back, 1: every other cycle, 2: random gaps
   task automatic drive_words(input int mode, input int first, input int last, input int start_at);
      int  w;
      int  guard;
      bit  v;
      w = first;
      guard = 0;
      while (w < last && guard < 1000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2) == 0;
            default: v = $urandom_range(0, 2) != 0;
         endcase
         in_valid = v;
         in_data  = words[w];
         start    = v && (w == start_at);
         if (v && in_ready) begin
            model_accept(w);
            w++;
         end
         guard++;
         @(negedge clock);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (w < last) begin
         n_cmp++;
         n_err++;
         $display("FAIL drive_timeout: accepted %0d words, required %0d", w, last);
      end
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_fabric_en"}, 64'(fabric_en), 64'd1);
      check({tag, "_word_cnt"}, 64'(word_cnt), 64'd56);
      check({tag, "_fmt_err"}, 64'(fmt_err), 64'(model_err));
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clock);
      #1;
      check({tag, "_pending_strobes"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic directed_words();
      for (int w = 0; w < 56; w++) begin
         case (w % 7)
            1, 3, 5: words[w] = 32'(w & 1);
            6:       words[w] = 32'h0000_FFFF;
            default: words[w] = 32'(w);
         endcase
      end
   endtask

   task automatic random_words();
      for (int w = 0; w < 56; w++) begin
         case (w % 7)
            1, 3, 5: words[w] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1));
            6:       words[w] = ($urandom_range(0, 7) == 0) ? $urandom : {16'd0, 16'($urandom)};
            default: words[w] = $urandom;
         endcase
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_lut_wr_en"}, 64'(lut_wr_en), 64'd0);
      check({tag, "_sb_wr_en"}, 64'(sb_wr_en), 64'd0);
      check({tag, "_fabric_en"}, 64'(fabric_en), 64'd0);
      check({tag, "_fmt_err"}, 64'(fmt_err), 64'd0);
      check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
      check({tag, "_lut_sel"}, 64'(lut_sel), 64'd0);
      check({tag, "_lut_data"}, 64'(lut_data), 64'd0);
      check({tag, "_sb_sel"}, 64'(sb_sel), 64'd0);
      check({tag, "_sb_data"}, 64'(sb_data), 64'd0);
   endtask

   initial begin
      int t0;
      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'd0;
      model_err = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_values("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_wait_in_ready", 64'(in_ready), 64'd0);

      // full frame, back-to-back
      directed_words();
      send_start();
      check("load_entry_in_ready", 64'(in_ready), 64'd1);
      check("load_entry_word_cnt", 64'(word_cnt), 64'd0);
      drive_words(0, 0, 56, -1);
      end_checks("b2b");

      // same frame, in_valid every other cycle
      send_start();
      t0 = cyc;
      drive_words(1, 0, 56, -1);
      check("alt_long_enough", 64'(cyc - t0 >= 110), 64'd1);
      end_checks("alt");

      // format errors on word 1 and word 6
      directed_words();
      words[1] = 32'h0000_0003;
      words[6] = 32'h0001_ABCD;
      send_start();
      drive_words(0, 0, 2, -1);
      check("err_word1_fmt_err", 64'(fmt_err), 64'd1);
      drive_words(0, 2, 56, -1);
      end_checks("err");

      // restart from DONE clears status
      directed_words();
      send_start();
      check("restart_fabric_en", 64'(fabric_en), 64'd0);
      check("restart_word_cnt", 64'(word_cnt), 64'd0);
      check("restart_in_ready", 64'(in_ready), 64'd1);
      check("restart_fmt_err", 64'(fmt_err), 64'd0);
      // start while loading is ignored
      drive_words(0, 0, 31, 30);
      check("start_in_load_word_cnt", 64'(word_cnt), 64'd31);
      check("start_in_load_in_ready", 64'(in_ready), 64'd1);
      drive_words(0, 31, 56, -1);
      end_checks("ignore_start");

      // reset mid-frame after word 20
      send_start();
      drive_words(0, 0, 21, -1);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_values("midreset");
      check("midreset_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("midreset_idle_fabric_en", 64'(fabric_en), 64'd0);
      check("midreset_idle_in_ready", 64'(in_ready), 64'd0);
      send_start();
      drive_words(0, 0, 56, -1);
      end_checks("after_reset");

      // random frames with random gaps and occasional format errors
      for (int f = 0; f < 4; f++) begin
         random_words();
         send_start();
         drive_words(2, 0, 56, -1);
         end_checks("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
